// File: rtl/maxpool2x2_stream_ctrl.sv
// 2x2 / stride-2 signed max-pool sequencer for one raster-ordered channel.
// Even rows fold horizontal pairs into a line buffer; odd/odd pixels emit a pooled result.
module maxpool2x2_stream_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_valid,
  input  logic signed [BITWIDTH-1:0] i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic signed [BITWIDTH-1:0] o_data,
  input  logic                       i_out_ready,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int NB = IMG_W / 2;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic signed [BITWIDTH-1:0] hold;
  logic signed [BITWIDTH-1:0] linebuf [NB];
  logic [IW-1:0]              lb_idx;
  logic                       accept, out_take, last_col, last_row;

  function automatic logic signed [BITWIDTH-1:0] smax(
    input logic signed [BITWIDTH-1:0] a,
    input logic signed [BITWIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  // Stall intake only while a finished result is still waiting downstream.
  assign o_ready  = (state == S_RUN) && !(o_valid && !i_out_ready);
  assign o_busy   = (state == S_RUN) || (state == S_DRAIN);
  assign o_done   = (state == S_DONE);
  assign accept   = i_valid && o_ready;
  assign out_take = o_valid && i_out_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign lb_idx   = IW'(col >> 1);

  // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_col && last_row) state_nxt = S_DRAIN;
      S_DRAIN: if (!o_valid || i_out_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      col     <= '0;
      row     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && i_start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A new result can only load while the register is empty or being drained.
      if (accept && row[0] && col[0]) begin
        o_data  <= smax(smax(linebuf[lb_idx], hold), i_data);
        o_valid <= 1'b1;
      end else if (out_take) begin
        o_valid <= 1'b0;
      end
    end
  end

  // NOTE: pixel hold and line buffer carry no reset; every entry is written before it is read each frame.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      if (!col[0]) begin
        hold <= i_data;
      end else if (!row[0]) begin
        linebuf[lb_idx] <= smax(hold, i_data);
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream_ctrl.sv
// Bench for maxpool2x2_stream_ctrl: a 4x4 instance for directed tables and backpressure,
// an 8x8 instance for randomized frames against a pooling reference model.
module tb_maxpool2x2_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, valid, out_ready, sel;
  logic signed [7:0] data;

  logic              r4, v4, b4, dn4, r8, v8, b8, dn8;
  logic signed [7:0] d4, d8;
  logic              rdy, vld, bsy, dn;
  logic signed [7:0] dout;

  assign rdy  = sel ? r8 : r4;
  assign vld  = sel ? v8 : v4;
  assign bsy  = sel ? b8 : b4;
  assign dn   = sel ? dn8 : dn4;
  assign dout = sel ? d8 : d4;

  maxpool2x2_stream_ctrl #(.BITWIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && !sel), .i_valid(valid && !sel),
    .i_data(data), .o_ready(r4), .o_valid(v4), .o_data(d4),
    .i_out_ready(out_ready), .o_busy(b4), .o_done(dn4)
  );

  maxpool2x2_stream_ctrl #(.BITWIDTH(8), .IMG_W(8), .IMG_H(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && sel), .i_valid(valid && sel),
    .i_data(data), .o_ready(r8), .o_valid(v8), .o_data(d8),
    .i_out_ready(out_ready), .o_busy(b8), .o_done(dn8)
  );

  int                n_checks = 0;
  int                n_err    = 0;
  int                cyc      = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                last_xfer_cyc = 0;
  bit                rand_ready = 1'b0;
  logic signed [7:0] img[$];
  logic signed [7:0] got[$];
  int                expq[$];

  typedef struct {
    string             name;
    logic signed [7:0] px[16];
    int                expv[4];
  } vec_t;

  vec_t vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every transfer and every done pulse.
  always @(negedge clk) begin
    if (vld && out_ready) begin
      got.push_back(dout);
      last_xfer_cyc = cyc;
    end
    if (dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  endtask

  // Reference: each pooled output is the max of its 2x2 window, emitted in raster order.
  function automatic void build_expected(input int w, input int h);
    expq.delete();
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        int m;
        m = img[(2 * pr) * w + 2 * pc];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (int'(img[(2 * pr + dr) * w + 2 * pc + dc]) > m)
              m = img[(2 * pr + dr) * w + 2 * pc + dc];
        expq.push_back(m);
      end
    end
  endfunction

  task automatic compare_outputs(input string tag);
    int n;
    check({tag, "_count"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_out%0d", tag, i), got[i], expq[i]);
  endtask

  task automatic begin_frame();
    start = 1'b1;
    valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  // Offers img[0..limit-1] in order; bubbles with the given percentage; optional stray start.
  task automatic feed(input int limit, input int bubble_pct, input int start_at);
    int k;
    int guard;
    bit acc;
    k = 0;
    guard = 0;
    while (k < limit && guard < 5000) begin
      valid = ($urandom_range(99) >= bubble_pct);
      data  = img[k];
      start = (k == start_at);
      @(negedge clk);
      acc = valid && rdy;
      step();
      if (acc) k++;
      guard++;
    end
    valid = 1'b0;
    start = 1'b0;
    check("feed_accepted", k, limit);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 1000) begin
      step();
      g++;
    end
    repeat (3) step();
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_idle_busy"}, bsy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {vld, rdy, bsy, dn}, 0);
    check({tag, "_data"}, dout, 0);
  endtask

  initial begin
    int mix[16];
    int d0;

    for (int i = 0; i < 16; i++) begin
      vecs[0].px[i] = 8'(i);
      vecs[1].px[i] = 8'(-1 - i);
    end
    vecs[0].name = "ramp";
    vecs[0].expv = '{5, 7, 13, 15};
    vecs[1].name = "negative";
    vecs[1].expv = '{-1, -3, -9, -11};
    mix = '{-128, -128, -128, -128,
            -128, -127,    1, -128,
               0, -128, -128, -128,
            -128, -128, -128,  127};
    for (int i = 0; i < 16; i++) vecs[2].px[i] = 8'(mix[i]);
    vecs[2].name = "min_value";
    vecs[2].expv = '{-127, 1, 0, 127};

    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    data = '0;
    out_ready = 1'b1;
    sel = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset4");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset8");
    rst_n = 1'b1;
    sel = 1'b0;
    step();

    // Directed 4x4 frames, full-rate downstream.
    for (int v = 0; v < 3; v++) begin
      img.delete();
      for (int i = 0; i < 16; i++) img.push_back(vecs[v].px[i]);
      got.delete();
      d0 = done_cnt;
      begin_frame();
      feed(16, 0, -1);
      wait_done(d0, vecs[v].name);
      check({vecs[v].name, "_count"}, got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
        check($sformatf("%s_out%0d", vecs[v].name, i), got[i], vecs[v].expv[i]);
      check({vecs[v].name, "_done_latency"}, done_cyc - last_xfer_cyc, 1);
    end

    // Backpressure: hold the first result for five cycles.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    build_expected(4, 4);
    got.delete();
    out_ready = 1'b0;
    d0 = done_cnt;
    begin_frame();
    fork
      feed(16, 0, -1);
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!vld && g < 200) begin
          @(negedge clk);
          g++;
        end
        check("bp_first_valid", vld, 1);
        for (int j = 0; j < 5; j++) begin
          check($sformatf("bp_ready_low%0d", j), rdy, 0);
          check($sformatf("bp_data_hold%0d", j), dout, 5);
          if (j < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done(d0, "bp");
    compare_outputs("bp");

    // Randomized 8x8 frames with input bubbles and random downstream stalls.
    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      img.delete();
      for (int i = 0; i < 64; i++) img.push_back(8'($urandom_range(255)));
      build_expected(8, 8);
      got.delete();
      rand_ready = 1'b1;
      d0 = done_cnt;
      begin_frame();
      feed(64, 30, -1);
      wait_done(d0, $sformatf("rand%0d", f));
      rand_ready = 1'b0;
      out_ready = 1'b1;
      compare_outputs($sformatf("rand%0d", f));
    end

    // Stray start while running must be ignored.
    img.delete();
    for (int i = 0; i < 64; i++) img.push_back(8'($urandom_range(255)));
    build_expected(8, 8);
    got.delete();
    d0 = done_cnt;
    begin_frame();
    feed(64, 10, 20);
    wait_done(d0, "start_in_run");
    compare_outputs("start_in_run");

    // Reset in the middle of row 3, then a clean frame.
    img.delete();
    for (int i = 0; i < 64; i++) img.push_back(8'($urandom_range(255)));
    begin_frame();
    feed(26, 20, -1);
    rst_n = 1'b0;
    repeat (2) step();
    check_reset_outputs("midreset");
    got.delete();
    rst_n = 1'b1;
    repeat (6) step();
    check("midreset_no_partial", got.size(), 0);
    img.delete();
    for (int i = 0; i < 64; i++) img.push_back(8'($urandom_range(255)));
    build_expected(8, 8);
    got.delete();
    d0 = done_cnt;
    begin_frame();
    feed(64, 20, -1);
    wait_done(d0, "after_reset");
    compare_outputs("after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
